// File: rtl/muu_value_get_mc_if.sv
// Request, per-channel value source and output stream of the multi-channel value-get formatter.
// The slave view is the formatter itself; the master view is whatever feeds and drains it.
interface muu_value_get_mc_if #(
    parameter int DATA_WIDTH = 512,
    parameter int META_WIDTH = 96,
    parameter int NUM_CH     = 4,
    parameter int CH_BITS    = 2,
    parameter int LEN_WIDTH  = 10,
    parameter int USER_BITS  = 3
);
    logic [META_WIDTH-1:0]            req_meta;
    logic [7:0]                       req_op;
    logic [LEN_WIDTH-1:0]             req_len;
    logic [CH_BITS-1:0]               req_ch;
    logic                             req_drop;
    logic [USER_BITS-1:0]             req_user;
    logic                             req_valid;
    logic                             req_ready;

    logic [NUM_CH*DATA_WIDTH-1:0]     val_data;
    logic [NUM_CH-1:0]                val_valid;
    logic [NUM_CH-1:0]                val_ready;

    logic [META_WIDTH+DATA_WIDTH-1:0] out_data;
    logic [7:0]                       out_user;
    logic                             out_valid;
    logic                             out_last;
    logic                             out_ready;

    modport slave (
        input  req_meta, req_op, req_len, req_ch, req_drop, req_user, req_valid,
        output req_ready,
        input  val_data, val_valid,
        output val_ready,
        output out_data, out_user, out_valid, out_last,
        input  out_ready
    );

    modport master (
        output req_meta, req_op, req_len, req_ch, req_drop, req_user, req_valid,
        input  req_ready,
        output val_data, val_valid,
        input  val_ready,
        input  out_data, out_user, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/muu_value_get_mc.sv
// Value-get response formatter: header plus value beats pulled from one of NUM_CH channels,
// split into packets of at most MAX_WORDS_IN_PACKET data beats, with a drop mode.
module muu_value_get_mc #(
    parameter int DATA_WIDTH          = 512,
    parameter int META_WIDTH          = 96,
    parameter int NUM_CH              = 4,
    parameter int CH_BITS             = 2,
    parameter int LEN_WIDTH           = 10,
    parameter int USER_BITS           = 3,
    parameter int MAX_WORDS_IN_PACKET = 160
) (
    input logic               clk,
    input logic               rst,
    muu_value_get_mc_if.slave bus
);
    localparam int WPB = DATA_WIDTH / 64;
    localparam int BW  = LEN_WIDTH + 1;
    localparam int PW  = $clog2(MAX_WORDS_IN_PACKET + 1);

    typedef enum logic [1:0] {IDLE, VALUE, CONT, DROP} state_t;
    state_t state, state_n;

    logic [META_WIDTH-1:0]            meta_q;
    logic [7:0]                       op_q;
    logic [CH_BITS-1:0]               ch_q;
    logic [USER_BITS-1:0]             user_q;
    logic [BW-1:0]                    rem_q;
    logic [PW-1:0]                    pkt_q;
    logic [15:0]                      seg_q;
    logic                             out_valid_q, out_last_q;
    logic [META_WIDTH+DATA_WIDTH-1:0] out_data_q;
    logic [7:0]                       out_user_q;

    logic                  free, req_fire, take, sel_valid, val_fire;
    logic                  ld_req, ld_data, ld_cont, last_n;
    logic [BW-1:0]         req_beats;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_CH-1:0]     vrdy;

    function automatic logic [DATA_WIDTH-1:0] hdr(logic [7:0] op, logic [USER_BITS-1:0] user,
                                                  logic [BW-1:0] bt, logic [15:0] seg);
        hdr        = '0;
        hdr[15:0]  = 16'hFFFF;
        hdr[23:16] = op;
        hdr[31:24] = 8'(user);
        hdr[47:32] = 16'(bt);
        hdr[63:48] = seg;
    endfunction

    assign req_beats     = ({1'b0, bus.req_len} + BW'(WPB - 1)) / BW'(WPB);
    assign free          = !out_valid_q | bus.out_ready;
    assign bus.req_ready = (state == IDLE) & free;
    assign req_fire      = bus.req_valid & bus.req_ready;
    // Drop mode drains the channel even while the header waits in the output register.
    assign take          = ((state == VALUE) & free) | (state == DROP);
    assign val_fire      = sel_valid & take;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        vrdy      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_BITS'(i)) begin
                sel_valid = bus.val_valid[i];
                sel_data  = bus.val_data[i*DATA_WIDTH +: DATA_WIDTH];
                vrdy[i]   = take;
            end
        end
    end
    assign bus.val_ready = vrdy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        ld_req  = 1'b0;
        ld_data = 1'b0;
        ld_cont = 1'b0;
        last_n  = 1'b0;
        case (state)
            IDLE: if (req_fire) begin
                ld_req = 1'b1;
                if (req_beats == '0) last_n = 1'b1;
                else if (bus.req_drop) begin
                    last_n  = 1'b1;
                    state_n = DROP;
                end else state_n = VALUE;
            end
            VALUE: if (val_fire) begin
                ld_data = 1'b1;
                if (rem_q == BW'(1)) begin
                    last_n  = 1'b1;
                    state_n = IDLE;
                end else if (pkt_q == PW'(MAX_WORDS_IN_PACKET - 1)) begin
                    last_n  = 1'b1;
                    state_n = CONT;
                end
            end
            CONT: if (free) begin
                ld_cont = 1'b1;
                state_n = VALUE;
            end
            DROP: if (val_fire && rem_q == BW'(1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q      <= '0;
            op_q        <= '0;
            ch_q        <= '0;
            user_q      <= '0;
            rem_q       <= '0;
            pkt_q       <= '0;
            seg_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= '0;
        end else begin
            // Loads only happen when free, so a new word may replace one being accepted.
            if (ld_req | ld_data | ld_cont) begin
                out_valid_q <= 1'b1;
                out_last_q  <= last_n;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (ld_req) begin
                meta_q     <= bus.req_meta;
                op_q       <= bus.req_op;
                ch_q       <= bus.req_ch;
                user_q     <= bus.req_user;
                rem_q      <= req_beats;
                pkt_q      <= '0;
                seg_q      <= '0;
                out_user_q <= 8'(bus.req_user);
                out_data_q <= {bus.req_meta, hdr(bus.req_op, bus.req_user,
                                                 bus.req_drop ? {BW{1'b0}} : req_beats, 16'd0)};
            end
            if (ld_data) begin
                out_data_q <= {meta_q, sel_data};
                rem_q      <= rem_q - BW'(1);
                pkt_q      <= pkt_q + PW'(1);
            end
            if (state == DROP && val_fire) rem_q <= rem_q - BW'(1);
            if (ld_cont) begin
                seg_q      <= seg_q + 16'd1;
                pkt_q      <= '0;
                out_data_q <= {meta_q, hdr(op_q, user_q, rem_q, seg_q + 16'd1)};
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_user  = out_user_q;
endmodule

// File: tb/tb_muu_value_get_mc.sv
// Scoreboard bench for muu_value_get_mc: expected beats queued at request accept, compared on output accept.
module tb_muu_value_get_mc;
    localparam int DW = 512, MW = 96, NCH = 4, CHB = 2, LW = 10, UB = 3, MAXW = 2;
    localparam int OW = MW + DW, WPB = DW / 64;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [7:0]    user;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [MW-1:0]  meta;
        logic [7:0]     op;
        logic [LW-1:0]  len;
        logic [CHB-1:0] ch;
        logic           drop;
        logic [UB-1:0]  user;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muu_value_get_mc_if #(.DATA_WIDTH(DW), .META_WIDTH(MW), .NUM_CH(NCH), .CH_BITS(CHB),
                          .LEN_WIDTH(LW), .USER_BITS(UB)) bus ();

    muu_value_get_mc #(.DATA_WIDTH(DW), .META_WIDTH(MW), .NUM_CH(NCH), .CH_BITS(CHB),
                       .LEN_WIDTH(LW), .USER_BITS(UB), .MAX_WORDS_IN_PACKET(MAXW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, failures = 0;
    beat_t exp_q[$];
    req_t  rq[$];
    logic [63:0] seen_w[$];
    logic        seen_l[$];
    int src_cnt[NCH], plan_cnt[NCH];
    int p_rdy, p_val, cur_ch;
    logic hold;
    logic [OW-1:0] prev_data;

    task automatic chk(string tag, logic [OW-1:0] act, logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(int c, int k);
        for (int j = 0; j < DW / 32; j++) pat[j*32 +: 32] = {c[7:0], k[15:0], j[7:0]};
    endfunction

    function automatic logic [DW-1:0] hdr(logic [7:0] op, logic [UB-1:0] u, int bt, int seg);
        hdr = '0;
        hdr[63:0] = {seg[15:0], bt[15:0], 8'(u), op, 16'hFFFF};
    endfunction

    function automatic req_t mk(int len, int ch, bit drop, int op, int user);
        req_t r;
        r.meta = {$urandom, $urandom, $urandom};
        r.op   = op[7:0];
        r.len  = len[LW-1:0];
        r.ch   = ch[CHB-1:0];
        r.drop = drop;
        r.user = user[UB-1:0];
        return r;
    endfunction

    task automatic push_exp(req_t r);
        int bt, rem, seg, n;
        bt = (int'(r.len) + WPB - 1) / WPB;
        if (bt == 0 || r.drop) begin
            exp_q.push_back('{{r.meta, hdr(r.op, r.user, 0, 0)}, 8'(r.user), 1'b1});
            plan_cnt[r.ch] += bt;
            return;
        end
        rem = bt;
        seg = 0;
        exp_q.push_back('{{r.meta, hdr(r.op, r.user, bt, 0)}, 8'(r.user), 1'b0});
        while (rem > 0) begin
            n = (rem < MAXW) ? rem : MAXW;
            for (int k = 0; k < n; k++) begin
                exp_q.push_back('{{r.meta, pat(r.ch, plan_cnt[r.ch])}, 8'(r.user), k == n - 1});
                plan_cnt[r.ch]++;
            end
            rem -= n;
            if (rem > 0) begin
                seg++;
                exp_q.push_back('{{r.meta, hdr(r.op, r.user, rem, seg)}, 8'(r.user), 1'b0});
            end
        end
    endtask

    task automatic tick();
        beat_t e;
        req_t  r;
        if (rq.size() > 0) begin
            bus.req_valid = 1'b1;
            bus.req_meta  = rq[0].meta;
            bus.req_op    = rq[0].op;
            bus.req_len   = rq[0].len;
            bus.req_ch    = rq[0].ch;
            bus.req_drop  = rq[0].drop;
            bus.req_user  = rq[0].user;
        end else bus.req_valid = 1'b0;
        bus.out_ready = ($urandom_range(99) < p_rdy);
        for (int c = 0; c < NCH; c++) begin
            bus.val_valid[c] = ($urandom_range(99) < p_val);
            bus.val_data[c*DW +: DW] = pat(c, src_cnt[c]);
        end
        #1;
        if (hold && !rst) begin
            chk("hold_vld", OW'(bus.out_valid), OW'(1));
            chk("hold_data", bus.out_data, prev_data);
        end
        if (bus.out_valid && bus.out_ready && !rst) begin
            seen_w.push_back(bus.out_data[63:0]);
            seen_l.push_back(bus.out_last);
            chk("exp_avail", OW'(exp_q.size() != 0), OW'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data", bus.out_data, e.data);
                chk("user", OW'(bus.out_user), OW'(e.user));
                chk("last", OW'(bus.out_last), OW'(e.last));
            end
        end
        hold = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
        if (bus.val_ready != '0 && !rst) chk("vrdy_sel", OW'(bus.val_ready), OW'(1 << cur_ch));
        for (int c = 0; c < NCH; c++)
            if (bus.val_valid[c] && bus.val_ready[c] && !rst) src_cnt[c]++;
        if (bus.req_valid && bus.req_ready && !rst) begin
            r = rq.pop_front();
            push_exp(r);
            cur_ch = int'(r.ch);
        end
        @(negedge clk);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((rq.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain", OW'(rq.size() + exp_q.size()), OW'(0));
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        hold = 1'b0;
        prev_data = '0;
        cur_ch = 0;
        bus.req_valid = 0; bus.req_meta = '0; bus.req_op = '0; bus.req_len = '0;
        bus.req_ch = '0; bus.req_drop = 0; bus.req_user = '0;
        bus.val_valid = '0; bus.val_data = '0; bus.out_ready = 0;
        for (int c = 0; c < NCH; c++) begin src_cnt[c] = 0; plan_cnt[c] = 0; end
        p_rdy = 100;
        p_val = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_vld", OW'(bus.out_valid), OW'(0));
        chk("rst_last", OW'(bus.out_last), OW'(0));
        chk("rst_data", bus.out_data, OW'(0));
        chk("rst_user", OW'(bus.out_user), OW'(0));
        chk("rst_rrdy", OW'(bus.req_ready), OW'(1));
        chk("rst_vrdy", OW'(bus.val_ready), OW'(0));

        // Reset while stalled in VALUE waiting on channel 0.
        rq.push_back(mk(64, 0, 0, 8'h01, 1));
        repeat (4) tick();
        chk("mid_in_value", OW'(bus.val_ready), OW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", OW'(bus.out_valid), OW'(0));
        chk("mid_rst_rrdy", OW'(bus.req_ready), OW'(1));
        chk("mid_rst_vrdy", OW'(bus.val_ready), OW'(0));
        hold = 1'b0;
        rq.delete();
        exp_q.delete();
        for (int c = 0; c < NCH; c++) plan_cnt[c] = src_cnt[c];

        // Zero-length value: header only.
        p_val = 70;
        seen_w.delete(); seen_l.delete();
        rq.push_back(mk(0, 0, 0, 8'h02, 5));
        drain(200);
        chk("len0_n", OW'(seen_w.size()), OW'(1));
        chk("len0_word", OW'(seen_w[0]), OW'(64'h0000_0000_0502_FFFF));
        chk("len0_last", OW'(seen_l[0]), OW'(1));

        // Two beats from channel 2.
        seen_w.delete(); seen_l.delete();
        rq.push_back(mk(16, 2, 0, 8'h33, 1));
        drain(200);
        chk("len16_n", OW'(seen_w.size()), OW'(3));
        chk("len16_hdr", OW'(seen_w[0]), OW'(64'h0000_0002_0133_FFFF));
        chk("len16_last", OW'({seen_l[0], seen_l[1], seen_l[2]}), OW'(3'b001));

        // Five beats split into packets of two.
        seen_w.delete(); seen_l.delete();
        rq.push_back(mk(40, 3, 0, 8'h11, 3));
        drain(400);
        chk("split_n", OW'(seen_w.size()), OW'(8));
        chk("split_h0", OW'(seen_w[0]), OW'(64'h0000_0005_0311_FFFF));
        chk("split_h1", OW'(seen_w[3]), OW'(64'h0001_0003_0311_FFFF));
        chk("split_h2", OW'(seen_w[6]), OW'(64'h0002_0001_0311_FFFF));
        chk("split_last", OW'({seen_l[0], seen_l[1], seen_l[2], seen_l[3],
                               seen_l[4], seen_l[5], seen_l[6], seen_l[7]}), OW'(8'b0010_0101));

        // Drop with a blocked output.
        seen_w.delete(); seen_l.delete();
        p_rdy = 0;
        p_val = 100;
        s0 = src_cnt[1];
        rq.push_back(mk(24, 1, 1, 8'h44, 2));
        repeat (8) tick();
        chk("drop_consumed", OW'(src_cnt[1] - s0), OW'(3));
        chk("drop_vld", OW'(bus.out_valid), OW'(1));
        chk("drop_last", OW'(bus.out_last), OW'(1));
        chk("drop_hdr", OW'(bus.out_data[63:0]), OW'(64'h0000_0000_0244_FFFF));
        p_rdy = 100;
        drain(200);
        chk("drop_n", OW'(seen_w.size()), OW'(1));

        // Random traffic with throttling on both sides.
        p_rdy = 70;
        p_val = 70;
        for (int i = 0; i < 1000; i++)
            rq.push_back(mk($urandom_range(40), $urandom_range(NCH - 1), $urandom_range(7) == 0,
                            $urandom_range(255), $urandom_range((1 << UB) - 1)));
        drain(60000);
        p_val = 100;
        repeat (20) tick();
        for (int c = 0; c < NCH; c++) chk("src_sync", OW'(src_cnt[c]), OW'(plan_cnt[c]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
